// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift opcodes and the shift sequencer state encoding.
package cpu_pkg;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_NOP = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-position shifter covering SLL, SRL and SRA; opcode 11 passes through.
module shift_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] next_r
);

   always_comb begin
      next_r = r;
      case (op)
         SH_SLL:  next_r = {r[WIDTH-2:0], 1'b0};
         SH_SRL:  next_r = {1'b0, r[WIDTH-1:1]};
         SH_SRA:  next_r = {r[WIDTH-1], r[WIDTH-1:1]};
         default: next_r = r;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit position per clock, shamt times, with a start/done handshake.
module shift_sequencer
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] num,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   shift_state_t     state;
   shift_state_t     state_next;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_step;
   logic [1:0]       op_held;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .r      (work),
      .op     (op_held),
      .next_r (work_step)
   );

   // Requests landing while a shift is in flight are dropped, not queued.
   assign accept = start && (state != SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         work    <= '0;
         op_held <= SH_SLL;
      end else begin
         state <= state_next;
         if (accept) begin
            work    <= num;
            count   <= shamt;
            op_held <= op;
         end else if (state == SHIFT) begin
            work  <= work_step;
            count <= count - SHW'(1);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start)
               state_next = (shamt != '0) ? SHIFT : DONE;
            else
               state_next = IDLE;
         end
         SHIFT: begin
            if (count == SHW'(1))
               state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
   assign result = work;

endmodule
